// File: rtl/qsys_byte_sequencer_if.sv
// Avalon-MM 32-bit control port bundle for qsys_byte_sequencer.
// master = Avalon master side, slave = sequencer side.
interface qsys_byte_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_ctrl_address;
    logic [31:0]       avs_ctrl_writedata;
    logic [3:0]        avs_ctrl_byteenable;
    logic              avs_ctrl_write;
    logic              avs_ctrl_read;
    logic [31:0]       avs_ctrl_readdata;
    logic              avs_ctrl_waitrequest;

    modport master (
        output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
               avs_ctrl_write, avs_ctrl_read,
        input  avs_ctrl_readdata, avs_ctrl_waitrequest
    );

    modport slave (
        input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
               avs_ctrl_write, avs_ctrl_read,
        output avs_ctrl_readdata, avs_ctrl_waitrequest
    );
endinterface

// File: rtl/qsys_byte_sequencer.sv
// Splits each 32-bit Avalon-MM transfer into ascending 8-bit device accesses, one per enabled lane.
// Optional per-lane stall timeout with sticky seq_error: define QSYS_BYTESEQ_TIMEOUT_EN.
module qsys_byte_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset_n,
    qsys_byte_sequencer_if.slave avs,
    output logic [ADDR_W+1:0]   device_address,
    output logic [7:0]          device_writedata,
    input  logic [7:0]          device_readdata,
    output logic                device_write,
    output logic                device_read,
    input  logic                device_waitrequest,
    output logic                seq_error
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state_reg;
    logic [3:0]         mask_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic               write_reg;
    logic [31:0]        readdata_reg;
    logic               waitrequest_reg;
    logic [ADDR_W+1:0]  dev_addr_reg;
    logic [7:0]         dev_wdata_reg;
    logic               dev_write_reg;
    logic               dev_read_reg;

    logic [7:0]         wr_byte [4];
    logic [7:0]         in_byte [4];
    logic [1:0]         cur_lane;
    logic [1:0]         nxt_lane;
    logic [1:0]         acc_lane;
    logic [3:0]         mask_clr;
    logic               timeout_hit;
    logic               lane_done;
    logic [7:0]         lane_rdata;
    logic               accept;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_byte[gi] = wdata_reg[8*gi +: 8];
            assign in_byte[gi] = avs.avs_ctrl_writedata[8*gi +: 8];
        end
    endgenerate

    assign accept     = avs.avs_ctrl_read | avs.avs_ctrl_write;
    assign cur_lane   = lowest_lane(mask_reg);
    assign mask_clr   = mask_reg & ~(4'b0001 << cur_lane);
    assign nxt_lane   = lowest_lane(mask_clr);
    assign acc_lane   = lowest_lane(avs.avs_ctrl_byteenable);
    assign lane_done  = !device_waitrequest || timeout_hit;
    // An aborted lane reads back as all ones so software can spot it.
    assign lane_rdata = timeout_hit ? 8'hFF : device_readdata;

`ifdef QSYS_BYTESEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;
    logic        seq_error_reg;

    assign timeout_hit = device_waitrequest && (tmo_cnt_reg == 16'(TIMEOUT - 1));
    assign seq_error   = seq_error_reg;

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            tmo_cnt_reg   <= '0;
            seq_error_reg <= 1'b0;
        end else begin
            if (state_reg != ACCESS || lane_done)
                tmo_cnt_reg <= '0;
            else
                tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            if (state_reg == ACCESS && timeout_hit)
                seq_error_reg <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign seq_error      = 1'b0;
`endif

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_reg       <= IDLE;
            mask_reg        <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            write_reg       <= 1'b0;
            readdata_reg    <= '0;
            waitrequest_reg <= 1'b1;
            dev_addr_reg    <= '0;
            dev_wdata_reg   <= '0;
            dev_write_reg   <= 1'b0;
            dev_read_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    waitrequest_reg <= 1'b1;
                    if (accept) begin
                        mask_reg     <= avs.avs_ctrl_byteenable;
                        addr_reg     <= avs.avs_ctrl_address;
                        wdata_reg    <= avs.avs_ctrl_writedata;
                        write_reg    <= avs.avs_ctrl_write;
                        readdata_reg <= '0;
                        if (avs.avs_ctrl_byteenable != 4'b0000) begin
                            // First lane is presented straight from the request so it issues next cycle.
                            state_reg     <= ACCESS;
                            dev_addr_reg  <= {avs.avs_ctrl_address, acc_lane};
                            dev_wdata_reg <= in_byte[acc_lane];
                            dev_write_reg <= avs.avs_ctrl_write;
                            dev_read_reg  <= !avs.avs_ctrl_write;
                        end else begin
                            state_reg       <= DONE;
                            waitrequest_reg <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (lane_done) begin
                        if (!write_reg)
                            readdata_reg[{cur_lane, 3'b000} +: 8] <= lane_rdata;
                        mask_reg <= mask_clr;
                        if (mask_clr == 4'b0000) begin
                            state_reg       <= DONE;
                            waitrequest_reg <= 1'b0;
                            dev_write_reg   <= 1'b0;
                            dev_read_reg    <= 1'b0;
                        end else begin
                            dev_addr_reg  <= {addr_reg, nxt_lane};
                            dev_wdata_reg <= wr_byte[nxt_lane];
                        end
                    end
                end
                DONE: begin
                    state_reg       <= IDLE;
                    waitrequest_reg <= 1'b1;
                end
                default: begin
                    state_reg       <= IDLE;
                    waitrequest_reg <= 1'b1;
                    dev_write_reg   <= 1'b0;
                    dev_read_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign avs.avs_ctrl_readdata    = readdata_reg;
    assign avs.avs_ctrl_waitrequest = waitrequest_reg;
    assign device_address           = dev_addr_reg;
    assign device_writedata         = dev_wdata_reg;
    assign device_write             = dev_write_reg;
    assign device_read              = dev_read_reg;

endmodule

// File: tb/tb_qsys_byte_sequencer.sv
// Directed bench for qsys_byte_sequencer with a behavioural byte-wide device.
// The timeout scenario runs only when QSYS_BYTESEQ_TIMEOUT_EN is defined.
module tb_qsys_byte_sequencer;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qsys_byte_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    logic [ADDR_W+1:0] device_address;
    logic [7:0]        device_writedata;
    logic [7:0]        device_readdata;
    logic              device_write;
    logic              device_read;
    logic              device_waitrequest;
    logic              seq_error;

    qsys_byte_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs                (bus),
        .device_address     (device_address),
        .device_writedata   (device_writedata),
        .device_readdata    (device_readdata),
        .device_write       (device_write),
        .device_read        (device_read),
        .device_waitrequest (device_waitrequest),
        .seq_error          (seq_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Device model: wait_cycles stall cycles per access, optional permanent stall on one lane.
    int         wait_cycles = 0;
    logic       stuck_en = 1'b0;
    logic [1:0] stuck_lane = 2'd0;
    logic [7:0] rd_bytes [4];
    int         wcnt = 0;
    logic       strobe;

    assign strobe = device_read | device_write;
    assign device_waitrequest = strobe &&
        ((wcnt < wait_cycles) || (stuck_en && device_address[1:0] == stuck_lane));
    assign device_readdata = rd_bytes[device_address[1:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (strobe && device_waitrequest) wcnt <= wcnt + 1;
        else                              wcnt <= 0;
    end

    logic [9:0] log_addr [32];
    logic [7:0] log_data [32];
    logic       log_wr   [32];
    int         log_cyc  [32];
    int         log_n = 0;
    int         strobe_cycles = 0;
    logic       overlap = 1'b0;

    always @(negedge clk) begin
        if (device_read && device_write) overlap <= 1'b1;
        if (strobe) strobe_cycles <= strobe_cycles + 1;
        if (strobe && !device_waitrequest && log_n < 32) begin
            log_addr[log_n] <= device_address;
            log_data[log_n] <= device_writedata;
            log_wr[log_n]   <= device_write;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after a posedge with the request dropped.
    task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output logic [31:0] rdata, output int lat);
        int start;
        start = cyc;
        bus.avs_ctrl_write      = wr;
        bus.avs_ctrl_read       = !wr;
        bus.avs_ctrl_address    = addr;
        bus.avs_ctrl_writedata  = data;
        bus.avs_ctrl_byteenable = be;
        lat   = -1;
        rdata = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.avs_ctrl_waitrequest) begin
                lat   = cyc - start;
                rdata = bus.avs_ctrl_readdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.avs_ctrl_write = 1'b0;
        bus.avs_ctrl_read  = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL xfer_complete: waitrequest never low within 200 cycles (addr %h)", addr);
        end
    endtask

    task automatic test_reset();
        bus.avs_ctrl_write = 1'b0;
        bus.avs_ctrl_read  = 1'b0;
        bus.avs_ctrl_address = '0;
        bus.avs_ctrl_writedata = '0;
        bus.avs_ctrl_byteenable = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.avs_ctrl_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitrequest: got %b want 1", bus.avs_ctrl_waitrequest); end
        checks++; if (bus.avs_ctrl_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 00000000", bus.avs_ctrl_readdata); end
        checks++; if ({device_read, device_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {device_read, device_write}); end
        checks++; if (device_address !== 10'h0 || device_writedata !== 8'h0) begin errors++; $display("FAIL reset_dev_bus: got addr %h data %h want 000 00", device_address, device_writedata); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error: got %b want 0", seq_error); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write_burst();
        logic [7:0]  exp_b [4];
        logic [31:0] rd;
        int lat, base, t0;
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        base = log_n; t0 = cyc;
        do_xfer(1'b1, 8'h12, 32'hA1B2C3D4, 4'b1111, rd, lat);
        $display("write addr 12 data A1B2C3D4 be 1111 latency %0d accesses %0d", lat, log_n - base);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wr4_latency: got %0d want 5", lat); end
        checks++; if (log_n - base !== 4) begin errors++; $display("FAIL wr4_count: got %0d want 4", log_n - base); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] ea;
            ea = 10'(10'h48 + i);
            checks++;
            if (log_addr[base+i] !== ea || log_data[base+i] !== exp_b[i] || log_wr[base+i] !== 1'b1 || log_cyc[base+i] !== t0 + 1 + i) begin
                errors++;
                $display("FAIL wr4_lane%0d: got addr %h data %h wr %b cyc %0d want %h %h 1 %0d",
                         i, log_addr[base+i], log_data[base+i], log_wr[base+i], log_cyc[base+i] - t0, ea, exp_b[i], 1 + i);
            end
        end
        idle(2);
    endtask

    task automatic test_read_wait();
        logic [31:0] rd;
        int lat, base, t0;
        wait_cycles = 2;
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h5A; rd_bytes[2] = 8'h22; rd_bytes[3] = 8'h7E;
        base = log_n; t0 = cyc;
        do_xfer(1'b0, 8'h05, 32'h0, 4'b1010, rd, lat);
        $display("read addr 05 be 1010 wait 2 readdata %h latency %0d", rd, lat);
        checks++; if (rd !== 32'h7E005A00) begin errors++; $display("FAIL rd_wait_data: got %h want 7E005A00", rd); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL rd_wait_latency: got %0d want 7", lat); end
        checks++; if (log_n - base !== 2) begin errors++; $display("FAIL rd_wait_count: got %0d want 2", log_n - base); end
        checks++;
        if (log_addr[base] !== 10'h015 || log_wr[base] !== 1'b0 || log_cyc[base] !== t0 + 3) begin
            errors++; $display("FAIL rd_wait_lane1: got addr %h wr %b cyc %0d want 015 0 3", log_addr[base], log_wr[base], log_cyc[base] - t0);
        end
        checks++;
        if (log_addr[base+1] !== 10'h017 || log_wr[base+1] !== 1'b0 || log_cyc[base+1] !== t0 + 6) begin
            errors++; $display("FAIL rd_wait_lane3: got addr %h wr %b cyc %0d want 017 0 6", log_addr[base+1], log_wr[base+1], log_cyc[base+1] - t0);
        end
        wait_cycles = 0;
        idle(3);
        checks++; if (bus.avs_ctrl_readdata !== 32'h7E005A00) begin errors++; $display("FAIL rd_hold: got %h want 7E005A00", bus.avs_ctrl_readdata); end
    endtask

    task automatic test_zero_be();
        logic [31:0] rd;
        int lat, s0;
        s0 = strobe_cycles;
        do_xfer(1'b1, 8'h33, 32'hFFFFFFFF, 4'b0000, rd, lat);
        $display("write addr 33 be 0000 latency %0d strobe cycles %0d", lat, strobe_cycles - s0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL be0_latency: got %0d want 1", lat); end
        checks++; if (strobe_cycles - s0 !== 0) begin errors++; $display("FAIL be0_strobes: got %0d want 0", strobe_cycles - s0); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, base;
        logic found;
        rd_bytes[0] = 8'h10; rd_bytes[1] = 8'h20; rd_bytes[2] = 8'h30; rd_bytes[3] = 8'h40;
        stuck_en = 1'b1; stuck_lane = 2'd2;
        bus.avs_ctrl_read = 1'b1;
        bus.avs_ctrl_address = 8'h07;
        bus.avs_ctrl_byteenable = 4'b1111;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobe && device_address[1:0] == 2'd2) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach_lane2: got no lane-2 access want one within 20 cycles"); end
        @(negedge clk);
        checks++; if (bus.avs_ctrl_readdata !== 32'h00002010) begin errors++; $display("FAIL mid_partial: got %h want 00002010", bus.avs_ctrl_readdata); end
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid lane 2: strobes %b waitrequest %b readdata %h", {device_read, device_write}, bus.avs_ctrl_waitrequest, bus.avs_ctrl_readdata);
        checks++; if ({device_read, device_write} !== 2'b00) begin errors++; $display("FAIL mid_strobes: got %b want 00", {device_read, device_write}); end
        checks++; if (bus.avs_ctrl_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_waitrequest: got %b want 1", bus.avs_ctrl_waitrequest); end
        checks++; if (bus.avs_ctrl_readdata !== 32'h0 || device_address !== 10'h0) begin errors++; $display("FAIL mid_regs: got rd %h addr %h want 00000000 000", bus.avs_ctrl_readdata, device_address); end
        bus.avs_ctrl_read = 1'b0;
        stuck_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = log_n;
        do_xfer(1'b0, 8'h07, 32'h0, 4'b0100, rd, lat);
        $display("read addr 07 be 0100 after reset readdata %h latency %0d", rd, lat);
        checks++; if (rd !== 32'h00300000 || lat !== 2) begin errors++; $display("FAIL post_reset_read: got %h lat %0d want 00300000 lat 2", rd, lat); end
        checks++; if (log_n - base !== 1 || log_addr[base] !== 10'h01E) begin errors++; $display("FAIL post_reset_access: got count %0d addr %h want 1 01E", log_n - base, log_addr[base]); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL post_reset_seq_error: got %b want 0", seq_error); end
        idle(2);
    endtask

`ifdef QSYS_BYTESEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd;
        int lat, base, t0;
        rd_bytes[0] = 8'h99; rd_bytes[1] = 8'h66;
        stuck_en = 1'b1; stuck_lane = 2'd0;
        base = log_n; t0 = cyc;
        do_xfer(1'b0, 8'h01, 32'h0, 4'b0011, rd, lat);
        stuck_en = 1'b0;
        $display("read addr 01 be 0011 lane0 stuck readdata %h latency %0d seq_error %b", rd, lat, seq_error);
        checks++; if (rd !== 32'h000066FF) begin errors++; $display("FAIL tmo_data: got %h want 000066FF", rd); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL tmo_latency: got %0d want 6", lat); end
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL tmo_seq_error: got %b want 1", seq_error); end
        checks++; if (log_n - base !== 1 || log_addr[base] !== 10'h005 || log_cyc[base] !== t0 + 5) begin
            errors++; $display("FAIL tmo_lane1: got count %0d addr %h cyc %0d want 1 005 5", log_n - base, log_addr[base], log_cyc[base] - t0);
        end
        idle(3);
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", seq_error); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat1, lat2, base;
        rd_bytes[2] = 8'h3C;
        base = log_n;
        do_xfer(1'b1, 8'h20, 32'h00001100, 4'b0010, rd, lat1);
        do_xfer(1'b0, 8'h21, 32'h0, 4'b0100, rd, lat2);
        $display("back-to-back write lat %0d then read lat %0d readdata %h", lat1, lat2, rd);
        checks++; if (lat1 !== 2 || lat2 !== 2) begin errors++; $display("FAIL b2b_latency: got %0d %0d want 2 2", lat1, lat2); end
        checks++; if (rd !== 32'h003C0000) begin errors++; $display("FAIL b2b_data: got %h want 003C0000", rd); end
        checks++; if (log_n - base !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", log_n - base); end
        checks++;
        if (log_wr[base] !== 1'b1 || log_addr[base] !== 10'h081 || log_data[base] !== 8'h11) begin
            errors++; $display("FAIL b2b_write: got wr %b addr %h data %h want 1 081 11", log_wr[base], log_addr[base], log_data[base]);
        end
        checks++;
        if (log_wr[base+1] !== 1'b0 || log_addr[base+1] !== 10'h086 || log_cyc[base+1] - log_cyc[base] !== 3) begin
            errors++; $display("FAIL b2b_read: got wr %b addr %h gap %0d want 0 086 3", log_wr[base+1], log_addr[base+1], log_cyc[base+1] - log_cyc[base]);
        end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL strobe_overlap: got %b want 0", overlap); end
        idle(2);
    endtask

    initial begin
        rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
        test_reset();
        test_write_burst();
        test_read_wait();
        test_zero_be();
        test_reset_mid();
`ifdef QSYS_BYTESEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/qsys_byte_sequencer.md
# qsys_byte_sequencer

Controller between a 32-bit Avalon-MM slave port and an 8-bit byte-wide device bus. Each 32-bit read or write is split into one 8-bit device access per enabled byte lane, issued in ascending lane order. Each access completes on the device waitrequest handshake. The Avalon master sees a single stalled transfer. The block sits in the Qsys root between the interconnect and 8-bit peripheral devices. It replaces direct byte-lane muxing with properly sequenced multi-byte accesses.

## Interface
Parameters:
- ADDR_W, 8, Avalon word-address width
- TIMEOUT, 255, device-stall limit in cycles, 1..65535 (used only with the timeout feature)

Ports:
- csi_MCLK_clk  in  1  single clock; all logic rising-edge
- rsi_MRST_reset_n  in  1  reset, asynchronous assert, active-low
- avs_ctrl_address  in  ADDR_W  word address
- avs_ctrl_writedata  in  32  write data
- avs_ctrl_byteenable  in  4  lane enables, bit i = bits [8i+7:8i]
- avs_ctrl_write / avs_ctrl_read  in  1  transfer requests, mutually exclusive
- avs_ctrl_readdata  out  32  registered read data
- avs_ctrl_waitrequest  out  1  stall
- device_address  out  ADDR_W+2  byte address {word address, lane[1:0]}
- device_writedata  out  8  lane write byte
- device_readdata  in  8  lane read byte
- device_write / device_read  out  1  device strobes
- device_waitrequest  in  1  device stall
- seq_error  out  1  sticky timeout flag (timeout feature only)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On read or write, latch address, writedata, byteenable (as a pending mask) and direction; clear the readdata register.
  - If the mask is nonzero, go to ACCESS; if the mask is 0, go to DONE.
- ACCESS:
  - The current lane is the lowest set bit of the pending mask.
  - Drive the strobe for the latched direction, device_address = {addr, lane} and device_writedata = the latched lane byte.
  - A lane completes at an edge where device_waitrequest = 0. On completion, capture device_readdata into readdata[8·lane+7:8·lane] (reads only) and clear that mask bit.
  - If the mask becomes empty, go to DONE; otherwise stay in ACCESS and move to the next lane.
- DONE: waitrequest = 0 for exactly one cycle, then go to IDLE.
- avs_ctrl_waitrequest = 1 in every state except DONE.
- Read lanes that are not enabled return 0x00.
- Once a transfer is accepted, it runs to completion even if the master drops read or write.
- Device strobes are low in IDLE and DONE; device_read and device_write are never both high.

## Timing
- Reset values:
  - waitrequest = 1
  - readdata = 0
  - device_read = device_write = 0
  - device_address = 0, device_writedata = 0
  - seq_error = 0
  - state = IDLE
- Latency: cycle 0 accept; one cycle per lane plus device wait cycles; DONE follows the last lane edge.
  - With a zero-wait device and n enabled lanes, waitrequest is low in cycle n+1.
  - byteenable = 0 completes in cycle 1.
- Lanes are issued back-to-back, with no idle cycle between lanes.
- A new transfer can be accepted in the cycle after DONE.
- readdata is valid while waitrequest = 0 and holds until the next accept.
- Reset asserted mid-transfer returns the block to the reset values immediately (asynchronously). The partial transfer is discarded.

## Configuration
- QSYS_BYTESEQ_TIMEOUT_EN defined:
  - A per-lane counter restarts at each lane start and counts edges with device_waitrequest = 1.
  - When it reaches TIMEOUT, the lane is forced complete: read byte = 0xFF, and seq_error is set. seq_error stays set until reset.
  - Sequencing then continues with the next lane.
- QSYS_BYTESEQ_TIMEOUT_EN undefined: no counter; the block waits indefinitely; seq_error is tied to 0.

## Test plan
- Write addr 0x12, data 0xA1B2C3D4, be 4'b1111, zero-wait device -> device writes at 0x48=D4, 0x49=C3, 0x4A=B2, 0x4B=A1 on consecutive cycles; waitrequest low in cycle 5.
- Read be 4'b1010, device returns 0x5A then 0x7E, 2 wait cycles per lane -> accesses to lanes 1 and 3 only; readdata 0x7E005A00.
- byteenable 4'b0000 write -> no device strobe; waitrequest low in cycle 1.
- Reset asserted while lane 2 is stalled -> strobes drop the same cycle; waitrequest = 1; the next transfer starts clean from IDLE.
- Timeout enabled, TIMEOUT=4, device_waitrequest stuck high on lane 0 of a 2-lane read -> lane 0 aborted after 4 cycles; readdata[7:0]=0xFF; seq_error=1; lane 1 proceeds normally.
- Back-to-back write then read -> second transfer accepted the cycle after DONE; no overlap of device_write and device_read.
